// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds FSM states, queue entry layout and address helpers.
package fetch_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 16;

    localparam logic [ADDR_W-1:0] PC_STEP = 16'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] align_hw(
        input logic [ADDR_W-1:0] a
    );
        return a & 16'hFFFE;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, instr} entries.
// Head reads as zero whenever the queue is empty.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int QDEPTH = 2,
    localparam int PW     = $clog2(QDEPTH),
    localparam int CW     = PW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         full,
    output logic         empty
);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    fetch_entry_t  mem [QDEPTH];
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(QDEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage, pointers and occupancy; flush empties in one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester
// with redirect handling feeding a small instruction queue.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_ADDR = 16'h0000,
    parameter int          QDEPTH     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_addr,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [INSTR_W-1:0]  instr_data,
    output logic [ADDR_W-1:0]   instr_pc
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW:0] QLIM = (CW + 1)'(QDEPTH);

    fetch_state_t      state;
    fetch_state_t      state_n;
    logic              req_n;
    logic [ADDR_W-1:0] addr_n;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] fetch_pc_n;
    logic [ADDR_W-1:0] pend;
    logic [ADDR_W-1:0] pend_n;
    logic [ADDR_W-1:0] raddr;

    logic              push;
    logic              pop;
    logic              q_full;
    logic              q_empty;
    logic [CW-1:0]     q_count;
    logic [CW:0]       occ_next;
    logic              room;
    fetch_entry_t      q_head;
    fetch_entry_t      q_in;

    assign raddr    = align_hw(redirect_addr);
    assign pop      = instr_valid & instr_ready;
    assign push     = (state == REQ) & imem_ack & ~redirect_valid & ~q_full;
    assign q_in     = '{pc: imem_addr, instr: imem_rdata};
    assign occ_next = redirect_valid ? '0 :
                      ({1'b0, q_count} + (CW + 1)'(push) - (CW + 1)'(pop));
    assign room     = (occ_next < QLIM);

    fetch_queue #(
        .QDEPTH(QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_entry(q_in),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign instr_valid = ~q_empty;
    assign instr_data  = q_head.instr;
    assign instr_pc    = q_head.pc;

    // Next-state logic for the request FSM and its address registers.
    always_comb begin
        state_n    = state;
        req_n      = imem_req;
        addr_n     = imem_addr;
        fetch_pc_n = fetch_pc;
        pend_n     = pend;
        unique case (state)
            IDLE: begin
                if (redirect_valid) begin
                    state_n = REQ;
                    req_n   = 1'b1;
                    addr_n  = raddr;
                end else if (room) begin
                    state_n = REQ;
                    req_n   = 1'b1;
                    addr_n  = fetch_pc;
                end
            end
            REQ: begin
                if (redirect_valid && imem_ack) begin
                    addr_n = raddr;
                end else if (redirect_valid) begin
                    state_n = DROP;
                    pend_n  = raddr;
                end else if (imem_ack) begin
                    if (room) begin
                        addr_n = imem_addr + PC_STEP;
                    end else begin
                        state_n    = IDLE;
                        req_n      = 1'b0;
                        fetch_pc_n = imem_addr + PC_STEP;
                    end
                end
            end
            DROP: begin
                if (redirect_valid) begin
                    pend_n = raddr;
                end
                if (imem_ack) begin
                    state_n = REQ;
                    addr_n  = redirect_valid ? raddr : pend;
                end
            end
            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
            end
        endcase
    end

    // Registered FSM state and memory request outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= RESET_ADDR;
            fetch_pc  <= RESET_ADDR;
            pend      <= RESET_ADDR;
        end else begin
            state     <= state_n;
            imem_req  <= req_n;
            imem_addr <= addr_n;
            fetch_pc  <= fetch_pc_n;
            pend      <= pend_n;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (QDEPTH = 2).
// Memory returns addr ^ 16'h5A5A so data can be predicted per pc.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_data;
    logic [15:0] instr_pc;

    int total;
    int fails;

    instr_fetch_unit #(
        .RESET_ADDR(16'h0000),
        .QDEPTH    (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc)
    );

    assign imem_rdata = imem_addr ^ 16'h5A5A;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mdat(input logic [15:0] pc);
        return pc ^ 16'h5A5A;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] wrap_seq [4];
        wrap_seq[0] = 16'hFFFC;
        wrap_seq[1] = 16'hFFFE;
        wrap_seq[2] = 16'h0000;
        wrap_seq[3] = 16'h0002;
        total = 0;
        fails = 0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 16'h0000;
        imem_ack       = 1'b0;
        instr_ready    = 1'b1;

        // reset state
        tick;
        tick;
        chk("rst_req",   32'(imem_req),    32'h0);
        chk("rst_addr",  32'(imem_addr),   32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_data",  32'(instr_data),  32'h0);
        chk("rst_pc",    32'(instr_pc),    32'h0);

        // zero-wait streaming
        imem_ack = 1'b1;
        rst_n    = 1'b1;
        tick;
        chk("str_req0",   32'(imem_req),    32'h1);
        chk("str_addr0",  32'(imem_addr),   32'h0);
        chk("str_valid0", 32'(instr_valid), 32'h0);
        for (int k = 1; k <= 3; k++) begin
            tick;
            chk("str_addr",  32'(imem_addr),  32'(2 * k));
            chk("str_valid", 32'(instr_valid), 32'h1);
            chk("str_pc",    32'(instr_pc),   32'(2 * (k - 1)));
            chk("str_data",  32'(instr_data), 32'(mdat(16'(2 * (k - 1)))));
        end

        // backpressure fills queue then stops requesting
        rst_n       = 1'b0;
        instr_ready = 1'b0;
        #1;
        chk("bp_rst_req",   32'(imem_req),    32'h0);
        chk("bp_rst_valid", 32'(instr_valid), 32'h0);
        tick;
        rst_n = 1'b1;
        tick;
        chk("bp_addr0", 32'(imem_addr), 32'h0);
        tick;
        chk("bp_addr1", 32'(imem_addr), 32'h2);
        chk("bp_pc0",   32'(instr_pc),  32'h0);
        tick;
        chk("bp_full_req", 32'(imem_req),   32'h0);
        chk("bp_hold_pc",  32'(instr_pc),   32'h0);
        chk("bp_hold_dat", 32'(instr_data), 32'(mdat(16'h0000)));
        tick;
        chk("bp_idle_req", 32'(imem_req), 32'h0);
        chk("bp_hold_pc2", 32'(instr_pc), 32'h0);
        instr_ready = 1'b1;
        tick;
        chk("bp_res_req",  32'(imem_req),  32'h1);
        chk("bp_res_addr", 32'(imem_addr), 32'h4);
        chk("bp_res_pc",   32'(instr_pc),  32'h2);
        tick;
        chk("bp_res_pc4",  32'(instr_pc),  32'h4);
        chk("bp_addr6",    32'(imem_addr), 32'h6);

        // redirect while waiting on ack at 6
        imem_ack       = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0100;
        tick;
        redirect_valid = 1'b0;
        chk("drop_req",   32'(imem_req),    32'h1);
        chk("drop_addr",  32'(imem_addr),   32'h6);
        chk("drop_flush", 32'(instr_valid), 32'h0);
        tick;
        chk("drop_addr2", 32'(imem_addr), 32'h6);
        imem_ack = 1'b1;
        tick;
        chk("drop_tgt",   32'(imem_addr),   32'h0100);
        chk("drop_noval", 32'(instr_valid), 32'h0);
        tick;
        chk("drop_pc",   32'(instr_pc),   32'h0100);
        chk("drop_data", 32'(instr_data), 32'(mdat(16'h0100)));

        // redirect coincident with ack
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0008;
        tick;
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
        chk("co_addr8", 32'(imem_addr), 32'h8);
        tick;
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0041;
        imem_ack       = 1'b1;
        tick;
        redirect_valid = 1'b0;
        chk("co_addr40", 32'(imem_addr),   32'h0040);
        chk("co_valid",  32'(instr_valid), 32'h0);
        tick;
        chk("co_pc40",  32'(instr_pc),  32'h0040);
        chk("co_addr42", 32'(imem_addr), 32'h0042);

        // wrap around top of address space
        redirect_valid = 1'b1;
        redirect_addr  = 16'hFFFC;
        tick;
        redirect_valid = 1'b0;
        chk("wrap_a0", 32'(imem_addr), 32'(wrap_seq[0]));
        for (int k = 1; k < 4; k++) begin
            tick;
            chk("wrap_addr", 32'(imem_addr), 32'(wrap_seq[k]));
            chk("wrap_pc",   32'(instr_pc),  32'(wrap_seq[k-1]));
        end

        // second redirect in DROP with ack uses newest target
        imem_ack       = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 16'h0200;
        tick;
        chk("d2_addr", 32'(imem_addr), 32'h0002);
        redirect_addr = 16'h0301;
        imem_ack      = 1'b1;
        tick;
        redirect_valid = 1'b0;
        imem_ack       = 1'b0;
        chk("d2_tgt",   32'(imem_addr),   32'h0300);
        chk("d2_valid", 32'(instr_valid), 32'h0);

        // async reset during outstanding request
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar_req",  32'(imem_req),  32'h0);
        chk("ar_addr", 32'(imem_addr), 32'h0);
        imem_ack = 1'b1;
        tick;
        chk("ar_hold_req", 32'(imem_req),    32'h0);
        chk("ar_valid",    32'(instr_valid), 32'h0);
        rst_n = 1'b1;
        tick;
        chk("ar_rel_req",  32'(imem_req),  32'h1);
        chk("ar_rel_addr", 32'(imem_addr), 32'h0);
        tick;
        chk("ar_pc0",  32'(instr_pc),  32'h0);
        chk("ar_addr2", 32'(imem_addr), 32'h2);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_ADDR, default 16'h0000, is the first fetch address after reset.
REQ-002 Parameter QDEPTH, default 2, is the instruction queue depth; legal values are 2 and 4.
REQ-003 clk  in  1  is the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  is the reset, asynchronous and active-low.
REQ-005 redirect_valid  in  1  requests a branch/jump redirect this cycle.
REQ-006 redirect_addr  in  16  is the redirect target; bit 0 is ignored and forced to 0.
REQ-007 imem_req  out  1  is the instruction-memory request, registered.
REQ-008 imem_addr  out  16  is the request address, registered and halfword-aligned.
REQ-009 imem_ack  in  1  is a single-cycle acknowledge; imem_rdata is valid in the same cycle.
REQ-010 imem_rdata  in  16  is the instruction word returned on ack.
REQ-011 instr_valid  out  1  indicates the queue head is valid.
REQ-012 instr_ready  in  1  means the decoder accepts the head; transfer occurs when valid and ready are both high at a rising edge.
REQ-013 instr_data  out  16  is the queue head instruction.
REQ-014 instr_pc  out  16  is the address the queue head was fetched from.

Function
REQ-015 The FSM SHALL have states IDLE (no request), REQ (request outstanding) and DROP (outstanding request whose data is discarded).
REQ-016 In REQ, imem_req SHALL stay high and imem_addr stable until an edge with imem_ack=1.
REQ-017 A new request SHALL start (IDLE->REQ) only if queue occupancy after the current edge is below QDEPTH.
REQ-018 On an ack edge in REQ, {imem_addr, imem_rdata} SHALL be pushed into the queue.
- If occupancy after the edge is below QDEPTH: stay in REQ, imem_addr += 2.
- Otherwise: go to IDLE with fetch_pc = imem_addr + 2.
REQ-019 With zero-wait memory and instr_ready held at 1, throughput SHALL be one instruction per cycle.
REQ-020 An acked instruction SHALL be visible on instr_valid/instr_data the cycle after the ack edge (1-cycle latency).
REQ-021 Address increments SHALL wrap modulo 2^16 (16'hFFFE + 2 = 16'h0000).
REQ-022 A redirect SHALL flush the queue at that edge, so instr_valid = 0 the next cycle.
REQ-023 On a redirect in IDLE, the unit SHALL enter REQ with imem_addr = redirect_addr at that edge.
REQ-024 On a redirect in REQ without ack, the unit SHALL enter DROP and keep imem_req/imem_addr unchanged. It latches redirect_addr as the pending target.
REQ-025 On a redirect in REQ coinciding with ack, the acked data SHALL be discarded and the unit enters REQ at redirect_addr.
REQ-026 In DROP, the ack data SHALL be discarded, and the ack edge moves the unit to REQ at the pending target.
REQ-027 A redirect in DROP SHALL overwrite the pending target; if ack occurs in the same cycle, the new target is used.
REQ-028 If a redirect coincides with an output transfer, the transfer counts as taken and the flush still applies.
REQ-029 No queue push SHALL ever occur when the queue is full, and the head SHALL stay stable while valid and not ready.

Reset
REQ-030 While rst_n = 0, the unit SHALL be in state IDLE with imem_req = 0, imem_addr = RESET_ADDR, queue empty, instr_valid = 0, instr_data = 0 and instr_pc = 0.
REQ-031 At the first rising edge with rst_n = 1, the unit SHALL enter REQ at RESET_ADDR.
REQ-032 Reset asserted mid-request SHALL abandon the request; an ack arriving in reset is ignored.

Structure
REQ-033 Package fetch_pkg SHALL hold the FSM state enum plus ADDR_W = 16, INSTR_W = 16 and PC_STEP = 2.
REQ-034 The queue SHALL be a sub-module fetch_queue: a QDEPTH-entry FIFO of {pc, instr} with push, pop, flush, count, full and empty.

Verification
REQ-035 Reset release with imem_ack tied to 1 and instr_ready = 1 -> imem_addr follows 0, 2, 4, 6 on consecutive cycles, and instr_pc follows one cycle later.
REQ-036 instr_ready = 0 with zero-wait memory -> exactly QDEPTH pushes (PCs 0 and 2 at QDEPTH = 2), then imem_req = 0. When ready rises, fetch resumes at 4.
REQ-037 Ack delayed 3 cycles at address 6, redirect to 16'h0100 in wait cycle 1 -> the ack data is dropped and the next request goes to 16'h0100. No instruction with pc = 6 is delivered.
REQ-038 Redirect to 16'h0041 coincident with ack at 8 -> data for 8 is discarded, and the next imem_addr is 16'h0040.
REQ-039 Redirect to 16'hFFFC followed by zero-wait fetch -> imem_addr follows FFFC, FFFE, 0000, 0002.
REQ-040 rst_n pulled low while a request is outstanding -> imem_req falls asynchronously, and after release the unit fetches from RESET_ADDR with the queue empty.
